// File: rtl/keypad_expr_buffer.sv
// 4x4 keypad scanner with debounce, feeding an ASCII token buffer for a calculator datapath.
// Tokens are appended until '#' terminates the expression; the buffer is read by index.
module keypad_expr_buffer #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DEB_SCANS = 4,
  parameter int unsigned DEPTH     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       expr_ready,
  output logic [7:0] count,
  output logic       overflow
);
  localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [7:0]      TokHash   = 8'h23;
  localparam logic [7:0]      CountFull = 8'(DEPTH - 1);
  localparam logic [7:0]      DebTarget = 8'(DEB_SCANS);

  typedef enum logic [1:0] {StIdle, StPressed, StDone} state_e;

  function automatic logic [7:0] key_token(input logic [3:0] k);
    logic [7:0] t;
    case (k)
      4'd0:    t = 8'h31;
      4'd1:    t = 8'h32;
      4'd2:    t = 8'h33;
      4'd3:    t = 8'h2B;
      4'd4:    t = 8'h34;
      4'd5:    t = 8'h35;
      4'd6:    t = 8'h36;
      4'd7:    t = 8'h2D;
      4'd8:    t = 8'h37;
      4'd9:    t = 8'h38;
      4'd10:   t = 8'h39;
      4'd11:   t = 8'h2A;
      4'd12:   t = 8'h28;
      4'd13:   t = 8'h30;
      4'd14:   t = 8'h29;
      default: t = 8'h23;
    endcase
    return t;
  endfunction

  // Scan state; hits_q counts row/column intersections this scan (2 means MULTI).
  logic            active_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      col_q;
  logic [1:0]      hits_q;
  logic [3:0]      key_q;

  logic       sample, scan_end, scan_single, scan_none;
  logic [1:0] col_hits, col_row, tot_hits;
  logic [3:0] scan_key;

  assign sample   = active_q && (div_q == DivLast);
  assign scan_end = sample && (col_q == 2'd3);
  assign col_out  = active_q ? ~(4'b0001 << col_q) : 4'hF;

  always_comb begin
    col_hits = 2'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_in[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_row = 2'(r);
      end
    end
    if (hits_q == 2'd2 || col_hits == 2'd2 || (hits_q == 2'd1 && col_hits == 2'd1)) begin
      tot_hits = 2'd2;
    end else begin
      tot_hits = hits_q | col_hits;
    end
    scan_key = (col_hits == 2'd1) ? {col_row, col_q} : key_q;
  end

  assign scan_single = scan_end && (tot_hits == 2'd1);
  assign scan_none   = scan_end && (tot_hits != 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      col_q    <= 2'd0;
      hits_q   <= 2'd0;
      key_q    <= 4'd0;
    end else if (!active_q) begin
      active_q <= 1'b1;
    end else if (sample) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
      if (col_q == 2'd3) begin
        hits_q <= 2'd0;
        key_q  <= 4'd0;
      end else begin
        hits_q <= tot_hits;
        key_q  <= scan_key;
      end
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // Entry FSM; hold_q blocks acceptance after clr until the keypad is seen released.
  state_e     state_q, state_d;
  logic [7:0] deb_q, deb_d, count_q, count_d;
  logic [3:0] cand_q, cand_d;
  logic       hold_q, hold_d, ovf_q, ovf_d;
  logic       we;
  logic [7:0] wtok;
  logic [7:0] deb_inc, run_len;

  assign deb_inc = (deb_q >= DebTarget) ? deb_q : deb_q + 8'd1;

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cand_d  = cand_q;
    hold_d  = hold_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wtok    = key_token(scan_key);
    run_len = 8'd1;
    if (clr) begin
      state_d = StIdle;
      count_d = 8'd0;
      ovf_d   = 1'b0;
      deb_d   = 8'd0;
      hold_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_end) begin
            if (hold_q) begin
              if (scan_none && deb_inc >= DebTarget) begin
                hold_d = 1'b0;
                deb_d  = 8'd0;
              end else begin
                deb_d = scan_none ? deb_inc : 8'd0;
              end
            end else if (scan_single) begin
              run_len = (deb_q != 8'd0 && cand_q == scan_key) ? deb_inc : 8'd1;
              cand_d  = scan_key;
              deb_d   = run_len;
              if (run_len >= DebTarget) begin
                deb_d = 8'd0;
                if (wtok == TokHash) begin
                  we      = 1'b1;
                  count_d = count_q + 8'd1;
                  state_d = StDone;
                end else if (count_q == CountFull) begin
                  ovf_d   = 1'b1;
                  state_d = StPressed;
                end else begin
                  we      = 1'b1;
                  count_d = count_q + 8'd1;
                  state_d = StPressed;
                end
              end
            end else begin
              deb_d = 8'd0;
            end
          end
        end
        StPressed: begin
          if (scan_end) begin
            if (scan_none && deb_inc >= DebTarget) begin
              state_d = StIdle;
              deb_d   = 8'd0;
            end else begin
              deb_d = scan_none ? deb_inc : 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      deb_q   <= 8'd0;
      cand_q  <= 4'd0;
      hold_q  <= 1'b0;
      count_q <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      cand_q  <= cand_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && !rst) mem[count_q[AddrW-1:0]] <= wtok;
  end

  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= (rd_addr >= count_q) ? TokHash : mem[rd_addr[AddrW-1:0]];
    end
  end

  assign rd_data    = rd_data_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign expr_ready = (state_q == StDone);

endmodule

// File: tb/tb_keypad_expr_buffer.sv
// Directed bench for keypad_expr_buffer: a keypad model drives row_in, a token scoreboard
// holds the expected buffer contents, and reads pop and compare them.
module tb_keypad_expr_buffer;
  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned DebScans = 2;
  localparam int unsigned Depth    = 32;
  localparam int          ScanCyc  = 4 * ScanDiv;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       expr_ready;
  logic [7:0] count;
  logic       overflow;

  keypad_expr_buffer #(
    .SCAN_DIV (ScanDiv),
    .DEB_SCANS(DebScans),
    .DEPTH    (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .row_in    (row_in),
    .col_out   (col_out),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .expr_ready(expr_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  logic [15:0] keys;
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  logic [7:0] tok_map [16] = '{8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h2D,
                               8'h37, 8'h38, 8'h39, 8'h2A, 8'h28, 8'h30, 8'h29, 8'h23};
  int digit_keys [10] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 13};

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [$];  // {index, token}
  int   m_cnt  = 0;
  logic m_done = 1'b0;
  logic m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input int k);
    logic [7:0] tok;
    tok = tok_map[k];
    if (!m_done) begin
      if (tok == 8'h23) begin
        exp_q.push_back({8'(m_cnt), tok});
        m_cnt++;
        m_done = 1'b1;
      end else if (m_cnt == Depth - 1) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back({8'(m_cnt), tok});
        m_cnt++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_cnt));
    check({tag, ".expr_ready"}, 32'(expr_ready), 32'(m_done));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Hold key k for hold_scans scans, then release for three scans.
  task automatic press(input int k, input int hold_scans, input logic valid);
    @(negedge clk);
    keys = 16'd1 << k;
    repeat (hold_scans * ScanCyc) @(negedge clk);
    keys = 16'd0;
    repeat (3 * ScanCyc) @(negedge clk);
    if (valid) model_accept(k);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
    check_status(tag);
    repeat (3 * ScanCyc) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic verify_buffer(input string tag);
    logic [15:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd(e[15:8]);
      check($sformatf("%s.rd[%0d]", tag, e[15:8]), 32'(rd_data), 32'(e[7:0]));
    end
    rd(8'(m_cnt));
    check($sformatf("%s.rd_past_count[%0d]", tag, m_cnt), 32'(rd_data), 32'h23);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev;
    logic       found;
    keys    = 16'd0;
    rst     = 1'b1;
    clr     = 1'b0;
    rd_addr = 8'd0;
    repeat (3) @(negedge clk);
    check("rst.col_out", 32'(col_out), 32'hF);
    check("rst.rd_data", 32'(rd_data), 32'h0);
    check_status("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_scan.col_out", 32'(col_out), 32'hE);

    // Reset during debounce throws the partial key away.
    @(negedge clk);
    keys = 16'd1 << 0;
    repeat (ScanCyc + 8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    keys = 16'd0;
    rst  = 1'b0;
    repeat (3 * ScanCyc) @(negedge clk);
    check_status("rst_mid_debounce");

    press(4, 3, 1'b1);
    check_status("single_key");
    verify_buffer("single_key");

    press(6, 1, 1'b0);
    check_status("glitch_one_scan");
    @(negedge clk);
    keys = (16'd1 << 2) | (16'd1 << 6);
    repeat (3 * ScanCyc) @(negedge clk);
    keys = 16'd0;
    repeat (3 * ScanCyc) @(negedge clk);
    check_status("glitch_multi");

    do_clr("clr_idle");
    press(0, 3, 1'b1);
    press(3, 3, 1'b1);
    press(1, 3, 1'b1);
    press(15, 3, 1'b1);
    check_status("expr");
    verify_buffer("expr");
    press(5, 3, 1'b1);
    check_status("done_ignores_key");

    do_clr("clr_done");
    press(9, 10, 1'b1);
    check_status("long_hold");
    verify_buffer("long_hold");

    do_clr("clr_before_fill");
    for (int i = 0; i < Depth - 1; i++) press(digit_keys[i % 10], 3, 1'b1);
    check_status("fill");
    press(5, 3, 1'b1);
    check_status("full_drop");
    press(15, 3, 1'b1);
    check_status("full_hash");
    verify_buffer("full");

    do_clr("clr_after_full");
    // Align a press to a scan start so the acceptance cycle is known.
    prev  = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 4 * ScanCyc && !found; i++) begin
      @(negedge clk);
      if (prev == 4'h7 && col_out == 4'hE) found = 1'b1;
      else prev = col_out;
    end
    check("scan_sync", 32'(found), 32'h1);
    keys = 16'd1 << 7;
    repeat (2 * ScanCyc - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_status("clr_coincident");
    repeat (3 * ScanCyc) @(negedge clk);
    check_status("clr_held_key_blocked");
    keys = 16'd0;
    repeat (3 * ScanCyc) @(negedge clk);
    check_status("clr_after_release");
    press(13, 3, 1'b1);
    check_status("after_clr_entry");
    verify_buffer("after_clr_entry");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_expr_buffer.md
KEYPAD_EXPR_BUFFER -- requirements
Module: keypad_expr_buffer

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each column is driven.
REQ-002 Parameter DEB_SCANS, default 4: consecutive identical full scans needed to accept a key.
REQ-003 Parameter DEPTH, default 32: expression buffer entries, power of two, 4..128.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 clr  input  1  one-cycle pulse; empties the buffer and re-arms entry.
REQ-007 row_in  input  4  keypad rows, active-low (external pull-ups).
REQ-008 col_out  output  4  keypad column drive, active-low, one-hot-low.
REQ-009 rd_addr  input  8  token index requested by the calculator datapath.
REQ-010 rd_data  output  8  token at rd_addr, registered.
REQ-011 expr_ready  output  1  high while a '#'-terminated expression is held.
REQ-012 count  output  8  number of tokens stored.
REQ-013 overflow  output  1  sticky; a key was dropped because the buffer was full.

Function
REQ-014 Scan: col_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, each column held SCAN_DIV cycles; row_in sampled on the last cycle of each column period.
REQ-015 Key index k = 4*row + col (row = index of the low row_in bit, col = index of the driven column).
REQ-016 Token map k0..k15 = '1','2','3','+','4','5','6','-','7','8','9','*','(','0',')','#', encoded as ASCII (0x31, 0x32, 0x33, 0x2B, 0x34, 0x35, 0x36, 0x2D, 0x37, 0x38, 0x39, 0x2A, 0x28, 0x30, 0x29, 0x23).
REQ-017 A full scan (4 columns) yields NONE, a single key k, or MULTI; MULTI (two or more low row/column intersections) is treated as NONE.
REQ-018 Debounce: a key is accepted once the same single key k is seen for DEB_SCANS consecutive full scans; any differing scan restarts the count.
REQ-019 FSM states: IDLE (no key held), PRESSED (key accepted, waiting for release), DONE (expression terminated).
REQ-020 IDLE -> PRESSED on acceptance; the token is written at index count and count increments in the same cycle.
REQ-021 PRESSED -> IDLE after DEB_SCANS consecutive NONE scans; no auto-repeat.
REQ-022 Writing '#' moves the FSM to DONE and sets expr_ready=1 on the next cycle; keys are ignored in DONE.
REQ-023 Full rule: when count == DEPTH-1, only '#' is written; any other accepted key is dropped and sets overflow=1.
REQ-024 Read: rd_data = buffer[rd_addr] one cycle after rd_addr is presented; if rd_addr >= count, rd_data = 0x23 ('#').
REQ-025 clr in any state: count=0, expr_ready=0, overflow=0, FSM -> IDLE on the next cycle; if a key is still held, it must be released before the next acceptance. Buffer contents are not erased.
REQ-026 clr in the same cycle as an acceptance: clr wins and nothing is written.
REQ-027 The scan counters run continuously in every state, including DONE.

Reset
REQ-028 On rst: col_out=1111, rd_data=0x00, count=0, expr_ready=0, overflow=0, FSM=IDLE, scan and debounce counters cleared.
REQ-029 On the first cycle after rst deasserts, col_out=1110 and scanning starts.
REQ-030 rst mid-scan or mid-debounce discards any partial key; no write occurs.

Verification (bench uses SCAN_DIV=4, DEB_SCANS=2)
REQ-031 Press row1/col0 for 3 full scans, then release -> buffer[0]=0x34, count=1, expr_ready=0.
REQ-032 Key sequence '1','+','2','#' -> count=4, expr_ready=1; rd_addr 0..4 -> rd_data 0x31, 0x2B, 0x32, 0x23, 0x23 (index 4 >= count).
REQ-033 Glitch: key held for 1 scan only, or two keys held together -> no write, count unchanged.
REQ-034 Enter 31 digits, then '5', then '#' -> '5' dropped, overflow=1, buffer[31]=0x23, count=32.
REQ-035 Key held continuously for 10 scans -> exactly one token written.
REQ-036 clr asserted in DONE, and clr coincident with an acceptance -> count=0, expr_ready=0, no write in the coincident case.
